spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI mode-0 slave front end. Sits between the external SPI pins and the RAM word engine.
//  Deserialises 10-bit MOSI frames into rx_data/rx_valid for the RAM.
//  For read-data frames (rx_data[9:8]=2'b11), it captures the RAM's tx_data on tx_valid and
//  serialises it on MISO. SCLK/SS_n/MOSI are oversampled in the clk domain; there is no SCLK clocking.
// PARAMETERS
//  WORD_SIZE    8   data bits per RAM word; frame length is WORD_SIZE+2
//  SYNC_STAGES  2   flip-flop stages on sclk/ss_n/mosi synchronisers (>=2)
// PORTS
//  clk       in   1            system clock, rising edge; must be >= 8x SCLK frequency
//  rst_n     in   1            asynchronous active-low reset
//  sclk      in   1            SPI clock from master, CPOL=0
//  ss_n      in   1            SPI slave select, active low
//  mosi      in   1            SPI data in, MSB first
//  miso      out  1            SPI data out, MSB first
//  rx_valid  out  1            one-clk pulse: rx_data holds a complete frame
//  rx_data   out  WORD_SIZE+2  received frame; [9:8]=cmd, [7:0]=addr/data
//  tx_valid  in   1            RAM read data valid (level; may stay high between reads)
//  tx_data   in   WORD_SIZE    RAM read data
//  frame_err out  1            one-clk pulse: ss_n deasserted mid-frame
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, bit counter=0, shift regs=0, synchronisers=idle values
//    (sclk=0, ss_n=1, mosi=0). Outputs: miso=0, rx_valid=0, rx_data=0, frame_err=0.
//    Reset mid-frame drops the frame: no rx_valid, no frame_err.
//  Synchronisers: sclk, ss_n and mosi pass through SYNC_STAGES flops.
//    Rising/falling SCLK edges come from a registered copy of the synced sclk.
//    Every event below refers to the synced signals.
//  States: IDLE, RECV, WAIT_TX, SEND, DONE.
//  IDLE: ss_n falls -> RECV with bit counter=0. SCLK edges are ignored while ss_n is high.
//  RECV: on each SCLK rise, shift mosi into rx_shift LSB (MSB-first frame) and count++.
//    On the 10th rise (count==WORD_SIZE+1):
//    - rx_data <= completed frame; rx_valid=1 for exactly the next clk.
//    - If frame[9:8]==2'b11 -> WAIT_TX; otherwise -> DONE.
//  WAIT_TX: a 1-clk guard after the rx_valid pulse. tx_valid is ignored during the rx_valid
//    cycle and the cycle after it (a stale tx_valid from the previous read must not be captured).
//    On the first later clk with tx_valid=1:
//    - tx_shift <= tx_data; miso <= tx_data[WORD_SIZE-1]; bit counter=0; -> SEND.
//    SCLK edges are ignored. miso=0 while waiting. There is no timeout; it waits until ss_n rises.
//  SEND: on each SCLK rise, count++. On each SCLK fall while count<WORD_SIZE, shift tx_shift left
//    and drive miso=new MSB. After the WORD_SIZE-th rise -> DONE.
//  DONE: all SCLK edges are ignored; miso=0; waits for ss_n high.
//  ss_n rises in any state -> IDLE next clk; miso=0; counters cleared.
//    If the state was RECV, WAIT_TX or SEND, frame_err pulses for 1 clk and no rx_valid is issued.
//    If the state was DONE or IDLE, there is no frame_err.
//  Simultaneous ss_n rise and 10th SCLK rise in the same clk: ss_n wins.
//    The frame is aborted and frame_err pulses.
//  rx_data holds its value between frames. It updates only on a complete 10-bit frame.
//  Latency: synced 10th SCLK rise -> rx_valid at +1 clk. tx_valid seen -> miso valid at +1 clk.
//  Frame lengths: non-read frame is 10 SCLK; read-data frame is 10+WORD_SIZE SCLK.
//    The master must keep SCLK low long enough for WAIT_TX, which is guaranteed by the 8x ratio.
// TESTING
//  1 Write-addr frame 10'b00_0000_0101 -> single rx_valid pulse, rx_data=10'h005, miso stays 0,
//    no frame_err.
//  2 Frames 10'h1A5 then 10'h3xx with the RAM model returning 8'hA5 on tx_valid ->
//    MISO bits 1,0,1,0,0,1,0,1 on SCLK rises 11..18.
//  3 ss_n raised after 5 SCLK bits -> no rx_valid, one frame_err pulse;
//    a following full frame 10'h2FF -> rx_data=10'h2FF.
//  4 tx_valid held high with stale tx_data=8'h11 and updated to 8'h3C one clk after rx_valid ->
//    MISO sends 8'h3C, not 8'h11.
//  5 rst_n pulsed low mid-SEND -> miso=0, rx_valid=0 immediately (async);
//    the next frame after reset is received correctly.
//  6 Back-to-back frames with ss_n high for 1 SCLK period; extra SCLK cycles in DONE ->
//    exactly one rx_valid per frame; extra edges ignored.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: oversamples SCLK/SS_n/MOSI in the clk domain,
// deserialises command frames for the RAM engine and serialises read data on MISO.
module spi_slave_if #(
    parameter int WORD_SIZE   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 rx_valid,
    output logic [WORD_SIZE+1:0] rx_data,
    input  logic                 tx_valid,
    input  logic [WORD_SIZE-1:0] tx_data,
    output logic                 frame_err
);

    localparam int FW = WORD_SIZE + 2;
    localparam int CW = $clog2(FW + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECV    = 3'd1,
        WAIT_TX = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_d_r;

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [FW-2:0]          rx_shift_r;
    logic [WORD_SIZE-2:0]   tx_shift_r;
    logic                   miso_r;
    logic                   rx_valid_r;
    logic [FW-1:0]          rx_data_r;
    logic                   frame_err_r;

    state_t                 state_nxt_s;
    logic [CW-1:0]          cnt_nxt_s;
    logic [FW-2:0]          rx_shift_nxt_s;
    logic [WORD_SIZE-2:0]   tx_shift_nxt_s;
    logic                   miso_nxt_s;
    logic                   rx_valid_nxt_s;
    logic [FW-1:0]          rx_data_nxt_s;
    logic                   frame_err_nxt_s;

    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   rise_s;
    logic                   fall_s;
    logic [FW-1:0]          frame_s;

    assign sclk_s  = sclk_sync_r[SYNC_STAGES-1];
    assign ss_s    = ss_sync_r[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_r[SYNC_STAGES-1];
    assign rise_s  = sclk_s & ~sclk_d_r;
    assign fall_s  = ~sclk_s & sclk_d_r;
    assign frame_s = {rx_shift_r, mosi_s};

    // Pin synchronisers plus the delayed SCLK copy used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            ss_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_d_r    <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            sclk_d_r    <= sclk_s;
        end
    end

    // Next-state and next-output logic; a high SS_n overrides every state.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        rx_shift_nxt_s  = rx_shift_r;
        tx_shift_nxt_s  = tx_shift_r;
        miso_nxt_s      = miso_r;
        rx_valid_nxt_s  = 1'b0;
        rx_data_nxt_s   = rx_data_r;
        frame_err_nxt_s = 1'b0;
        if (ss_s) begin
            state_nxt_s     = IDLE;
            cnt_nxt_s       = CW'(0);
            rx_shift_nxt_s  = '0;
            tx_shift_nxt_s  = '0;
            miso_nxt_s      = 1'b0;
            frame_err_nxt_s = (state_r == RECV) || (state_r == WAIT_TX) || (state_r == SEND);
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = RECV;
                    cnt_nxt_s   = CW'(0);
                    miso_nxt_s  = 1'b0;
                end
                RECV: begin
                    if (rise_s) begin
                        rx_shift_nxt_s = frame_s[FW-2:0];
                        if (cnt_r == CW'(FW - 1)) begin
                            rx_data_nxt_s  = frame_s;
                            rx_valid_nxt_s = 1'b1;
                            cnt_nxt_s      = CW'(0);
                            state_nxt_s    = (frame_s[FW-1:FW-2] == 2'b11) ? WAIT_TX : DONE;
                        end else begin
                            cnt_nxt_s = cnt_r + CW'(1);
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                WAIT_TX: begin
                    // Counter doubles as the two-cycle guard so a stale tx_valid is never taken.
                    miso_nxt_s = 1'b0;
                    if (cnt_r < CW'(2)) begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end else if (tx_valid) begin
                        tx_shift_nxt_s = tx_data[WORD_SIZE-2:0];
                        miso_nxt_s     = tx_data[WORD_SIZE-1];
                        cnt_nxt_s      = CW'(0);
                        state_nxt_s    = SEND;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                SEND: begin
                    if (rise_s) begin
                        cnt_nxt_s = cnt_r + CW'(1);
                        if (cnt_r == CW'(WORD_SIZE - 1)) begin
                            state_nxt_s = DONE;
                            miso_nxt_s  = 1'b0;
                        end else begin
                            state_nxt_s = SEND;
                        end
                    // A fall before the first SEND rise is the tail of the command frame.
                    end else if (fall_s && (cnt_r != CW'(0)) && (cnt_r < CW'(WORD_SIZE))) begin
                        miso_nxt_s     = tx_shift_r[WORD_SIZE-2];
                        tx_shift_nxt_s = {tx_shift_r[WORD_SIZE-3:0], 1'b0};
                    end else begin
                        miso_nxt_s = miso_r;
                    end
                end
                DONE: begin
                    miso_nxt_s = 1'b0;
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CW'(0);
                    miso_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= CW'(0);
            rx_shift_r  <= '0;
            tx_shift_r  <= '0;
            miso_r      <= 1'b0;
            rx_valid_r  <= 1'b0;
            rx_data_r   <= '0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            rx_shift_r  <= rx_shift_nxt_s;
            tx_shift_r  <= tx_shift_nxt_s;
            miso_r      <= miso_nxt_s;
            rx_valid_r  <= rx_valid_nxt_s;
            rx_data_r   <= rx_data_nxt_s;
            frame_err_r <= frame_err_nxt_s;
        end
    end

    assign miso      = miso_r;
    assign rx_valid  = rx_valid_r;
    assign rx_data   = rx_data_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: an SPI master task drives frames, a small RAM model
// answers read-data frames, and pulse counters are compared with expectations.
module tb_spi_slave_if;

    localparam int HP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;
    int mh_cnt = 0;

    logic [7:0] mem [256];
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    bit         expect_read = 1'b0;

    spi_slave_if #(.WORD_SIZE(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse and activity counters sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid)  rv_cnt <= rv_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (miso)      mh_cnt <= mh_cnt + 1;
    end

    // RAM model: presents read data one clk after the rx_valid pulse, then holds tx_valid high.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid && expect_read) begin
                @(posedge clk);
                @(negedge clk);
                tx_data  = mem[rd_addr];
                tx_valid = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // abort_at: -1 none, 0..9 raise SS_n before that command bit, 10..17 before that read bit.
    task automatic run_frame(input logic [9:0] frame, input int abort_at, input bit by_reset,
                             input bit simul, input int extra);
        int         rv0, fe0, mh0;
        bit         is_rd, aborted, rx_ok;
        logic [7:0] exp_b, got_b;
        rv0 = rv_cnt; fe0 = fe_cnt; mh0 = mh_cnt;
        is_rd = (frame[9:8] == 2'b11);
        aborted = 1'b0;
        exp_b = mem[rd_addr];
        got_b = 8'h00;
        expect_read = is_rd;
        ss_n = 1'b0;
        tick(HP);
        for (int i = 0; i < 10; i++) begin
            if (i == abort_at) begin aborted = 1'b1; break; end
            mosi = frame[9-i];
            tick(HP);
            sclk = 1'b1;
            if (simul && i == 9) ss_n = 1'b1;
            tick(HP);
            sclk = 1'b0;
        end
        rx_ok = !aborted && !simul;
        if (rx_ok && is_rd) begin
            tick(8);
            for (int j = 0; j < 8; j++) begin
                if (abort_at == 10 + j) begin
                    aborted = 1'b1;
                    if (by_reset) begin
                        chk_eq("pre_rst_miso", {31'd0, miso}, {31'd0, exp_b[7-j]});
                        rst_n = 1'b0;
                        #1;
                        chk_eq("rst_miso", {31'd0, miso}, 32'd0);
                        chk_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
                        chk_eq("rst_rx_data", {22'd0, rx_data}, 32'd0);
                        tick(3);
                        ss_n = 1'b1;
                        tick(2);
                        rst_n = 1'b1;
                    end
                    break;
                end
                tick(HP);
                got_b[7-j] = miso;
                sclk = 1'b1;
                tick(HP);
                sclk = 1'b0;
            end
        end
        if (rx_ok && !aborted) begin
            repeat (extra) begin
                mosi = 1'($urandom);
                tick(HP);
                sclk = 1'b1;
                tick(HP);
                sclk = 1'b0;
            end
        end
        tick(HP);
        ss_n = 1'b1;
        tick(2 * HP);
        chk_eq("rx_valid_pulses", rv_cnt - rv0, rx_ok ? 32'd1 : 32'd0);
        chk_eq("frame_err_pulses", fe_cnt - fe0, ((aborted && !by_reset) || simul) ? 32'd1 : 32'd0);
        if (rx_ok) chk_eq("rx_data", {22'd0, rx_data}, by_reset ? 32'd0 : {22'd0, frame});
        if (rx_ok && is_rd && !aborted) chk_eq("miso_byte", {24'd0, got_b}, {24'd0, exp_b});
        if (!is_rd) chk_eq("miso_idle", mh_cnt - mh0, 32'd0);
        if (rx_ok) begin
            case (frame[9:8])
                2'b00:   wr_addr = frame[7:0];
                2'b01:   mem[wr_addr] = frame[7:0];
                2'b10:   rd_addr = frame[7:0];
                default: ;
            endcase
        end
        expect_read = 1'b0;
    endtask

    initial begin
        logic [9:0] f;
        int         ab;
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
        tick(3);
        chk_eq("reset_miso", {31'd0, miso}, 32'd0);
        chk_eq("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk_eq("reset_rx_data", {22'd0, rx_data}, 32'd0);
        chk_eq("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        tick(4);

        run_frame(10'h005, -1, 1'b0, 1'b0, 0);
        run_frame(10'h1A5, -1, 1'b0, 1'b0, 0);
        run_frame(10'h205, -1, 1'b0, 1'b0, 0);
        run_frame(10'h300, -1, 1'b0, 1'b0, 0);
        run_frame(10'h155, 5, 1'b0, 1'b0, 0);
        run_frame(10'h2FF, -1, 1'b0, 1'b0, 0);
        run_frame(10'h006, -1, 1'b0, 1'b0, 0);
        run_frame(10'h111, -1, 1'b0, 1'b0, 0);
        run_frame(10'h007, -1, 1'b0, 1'b0, 0);
        run_frame(10'h13C, -1, 1'b0, 1'b0, 0);
        run_frame(10'h206, -1, 1'b0, 1'b0, 0);
        run_frame(10'h300, -1, 1'b0, 1'b0, 0);
        run_frame(10'h207, -1, 1'b0, 1'b0, 0);
        run_frame(10'h3C3, -1, 1'b0, 1'b0, 0);
        run_frame(10'h0AA, -1, 1'b0, 1'b1, 0);
        run_frame(10'h008, -1, 1'b0, 1'b0, 0);
        run_frame(10'h1FF, -1, 1'b0, 1'b0, 0);
        run_frame(10'h208, -1, 1'b0, 1'b0, 0);
        run_frame(10'h300, 13, 1'b1, 1'b0, 0);
        run_frame(10'h2FF, -1, 1'b0, 1'b0, 0);
        run_frame(10'h312, -1, 1'b0, 1'b0, 0);
        run_frame(10'h012, -1, 1'b0, 1'b0, 3);
        run_frame(10'h3AB, -1, 1'b0, 1'b0, 2);
        run_frame(10'h3AB, 15, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            f = 10'($urandom);
            ab = -1;
            if ($urandom_range(0, 7) == 0)
                ab = (f[9:8] == 2'b11) ? int'($urandom_range(0, 17)) : int'($urandom_range(0, 9));
            run_frame(f, ab, 1'b0, 1'b0, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
